// File: rtl/gate_pkg.sv
// Shared types and helpers for the registered logic-gate array.
package gate_pkg;

    localparam int OP_W = 3;

    // Requested frame operation; codes 6 and 7 are reserved.
    typedef enum logic [OP_W-1:0] {
        GATE_AND  = 3'd0,
        GATE_OR   = 3'd1,
        GATE_XOR  = 3'd2,
        GATE_NAND = 3'd3,
        GATE_NOR  = 3'd4,
        GATE_XNOR = 3'd5
    } gate_op_e;

    // Operation actually applied while folding; inversion happens once at frame close.
    typedef enum logic [1:0] {
        BASE_AND = 2'd0,
        BASE_OR  = 2'd1,
        BASE_XOR = 2'd2
    } base_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    // Reserved codes map to AND; their result is forced to zero anyway.
    function automatic base_op_e base_of(input logic [OP_W-1:0] op);
        base_op_e b;
        case (op)
            GATE_OR,  GATE_NOR:  b = BASE_OR;
            GATE_XOR, GATE_XNOR: b = BASE_XOR;
            default:             b = BASE_AND;
        endcase
        return b;
    endfunction

    function automatic logic is_inverted(input logic [OP_W-1:0] op);
        return (op == GATE_NAND) || (op == GATE_NOR) || (op == GATE_XNOR);
    endfunction

    function automatic logic is_reserved(input logic [OP_W-1:0] op);
        return op > GATE_XNOR;
    endfunction

endpackage

// File: rtl/gate_bitwise_reduce.sv
// Combinational fold of NIN operands into one WIDTH-bit word under a base op.
module gate_bitwise_reduce
    import gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NIN   = 2
) (
    input  logic [NIN*WIDTH-1:0] data_i,
    input  base_op_e             op_i,
    output logic [WIDTH-1:0]     red_o
);

    // Operand 0 seeds the fold; the rest are combined in order.
    always_comb begin
        logic [WIDTH-1:0] r;
        r = data_i[WIDTH-1:0];
        for (int k = 1; k < NIN; k++) begin
            case (op_i)
                BASE_OR:  r = r | data_i[k*WIDTH +: WIDTH];
                BASE_XOR: r = r ^ data_i[k*WIDTH +: WIDTH];
                default:  r = r & data_i[k*WIDTH +: WIDTH];
            endcase
        end
        red_o = r;
    end

endmodule

// File: rtl/gate_array_accum.sv
// Multi-beat bitwise gate accumulator with a one-entry registered result.
module gate_array_accum
    import gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NIN   = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NIN*WIDTH-1:0] in_data,
    input  logic [OP_W-1:0]      in_op,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_err
);

    state_e           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_err_q, out_err_d;

    logic             fire;
    logic [OP_W-1:0]  cur_op;
    base_op_e         cur_base;
    logic [WIDTH-1:0] beat_red;
    logic [WIDTH-1:0] acc_fold;
    logic [WIDTH-1:0] acc_new;
    logic [CNT_W-1:0] cnt_new;
    logic [WIDTH-1:0] result;

    // A full output register stalls every beat, last or not.
    assign in_ready = !out_valid_q || out_ready;
    assign fire     = in_valid && in_ready;

    // The frame op is taken from the first beat and held for the rest.
    assign cur_op   = (state_q == ST_IDLE) ? in_op : op_q;
    assign cur_base = base_of(cur_op);

    gate_bitwise_reduce #(
        .WIDTH (WIDTH),
        .NIN   (NIN)
    ) u_reduce (
        .data_i (in_data),
        .op_i   (cur_base),
        .red_o  (beat_red)
    );

    // Fold the reduced beat into the running partial result.
    always_comb begin
        case (cur_base)
            BASE_OR:  acc_fold = acc_q | beat_red;
            BASE_XOR: acc_fold = acc_q ^ beat_red;
            default:  acc_fold = acc_q & beat_red;
        endcase
    end

    assign acc_new = (state_q == ST_IDLE) ? beat_red : acc_fold;
    assign cnt_new = (state_q == ST_IDLE) ? CNT_W'(1)
                   : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
    assign result  = is_reserved(cur_op) ? '0
                   : (is_inverted(cur_op) ? ~acc_new : acc_new);

    // Next-state: frame progress, result load on the last beat, pop on out_ready.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_err_d   = out_err_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (fire) begin
            op_d  = cur_op;
            acc_d = acc_new;
            cnt_d = cnt_new;
            if (in_last) begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b1;
                out_data_d  = result;
                out_count_d = cnt_new;
                out_err_d   = is_reserved(cur_op);
            end else begin
                state_d = ST_ACCUM;
            end
        end
    end

    // State and output registers; reset drops any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_err   = out_err_q;

endmodule
